// File: rtl/kypd_pkg.sv
// kypd_pkg: shared types and constants for the 4x4 keypad scan reader.
//   - kypd_state_e : debounce FSM states
//   - scan_res_e   : classification of one full 16-key scan
//   - KEY_MAP      : hex code for each key, indexed by {col_idx, row_idx}
//   - key_lookup() : KEY_MAP accessor
package kypd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    PRESSED,
    RELEASE
  } kypd_state_e;

  typedef enum logic [1:0] {
    NONE,
    SINGLE,
    MULTI
  } scan_res_e;

  // Nibble k holds the code for key index k = {col, row}.
  // col0: 1 4 7 0 | col1: 2 5 8 F | col2: 3 6 9 E | col3: A B C D
  localparam logic [63:0] KEY_MAP = {
    4'hD, 4'hC, 4'hB, 4'hA,
    4'hE, 4'h9, 4'h6, 4'h3,
    4'hF, 4'h8, 4'h5, 4'h2,
    4'h0, 4'h7, 4'h4, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [3:0] idx);
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/kypd_scan_rdr_sync.sv
// sync_2ff: two-flop synchronizer for a bus of independent async inputs.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   d            : asynchronous input bus
//   q            : synchronized output (2-cycle latency), RESET_VAL in reset
module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] stab;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= RESET_VAL;
      stab <= RESET_VAL;
    end else begin
      meta <= d;
      stab <= meta;
    end
  end

  assign q = stab;

endmodule

// File: rtl/kypd_scan_rdr.sv
// kypd_scan_rdr: 4x4 matrix keypad scanner with scan-level debounce.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   row          : keypad rows, async, pulled up, low = pressed
//   col          : column drive, one-hot-low
//   key_code     : hex code of the last accepted key
//   key_valid    : one-cycle strobe per accepted press
//   key_held     : high while the accepted key is considered down
//   digit        : {enable, key_code, dp} for a display-driver digit input
module kypd_scan_rdr
  import kypd_pkg::*;
#(
  parameter int SCAN_TICKS     = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [5:0] digit
);

  localparam int              TW        = $clog2(SCAN_TICKS);
  localparam int              NW        = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [NW-1:0]   N_DONE    = NW'(DEBOUNCE_SCANS);

  logic [3:0]    rs;
  logic [TW-1:0] tick;
  logic [1:0]    col_idx;
  logic [11:0]   samp_lo;   // captured rows of columns 0..2
  logic          tick_last;
  logic          eos;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'b1111)) u_row_sync (
    .clock (clock),
    .reset (reset),
    .d     (row),
    .q     (rs)
  );

  assign tick_last = (tick == TICK_LAST);
  assign eos       = tick_last && (col_idx == 2'd3);
  assign col       = ~(4'b0001 << col_idx);

  // Column 3 is never stored: the end-of-scan decision uses its live sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      tick    <= '0;
      col_idx <= 2'd0;
      samp_lo <= '1;
    end else if (tick_last) begin
      tick    <= '0;
      col_idx <= col_idx + 2'd1;
      case (col_idx)
        2'd0:    samp_lo[3:0]  <= rs;
        2'd1:    samp_lo[7:4]  <= rs;
        2'd2:    samp_lo[11:8] <= rs;
        default: ;
      endcase
    end else begin
      tick <= tick + TW'(1);
    end
  end

  // Scan classification over all 16 keys, bit index = {col, row}.
  logic [15:0] low_bits;
  logic [4:0]  low_cnt;
  logic [3:0]  hit_idx;
  logic [3:0]  hit_code;
  scan_res_e   res;

  assign low_bits = ~{rs, samp_lo};

  always_comb begin
    low_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (low_bits[i]) begin
        low_cnt = low_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
    if (low_cnt == 5'd0)      res = NONE;
    else if (low_cnt == 5'd1) res = SINGLE;
    else                      res = MULTI;
  end

  assign hit_code = key_lookup(hit_idx);

  // Debounce FSM
  // state   | meaning
  // IDLE    | no key accepted, waiting for a lone key
  // CONFIRM | same lone key seen n consecutive scans
  // PRESSED | key accepted and still down
  // RELEASE | key-free (or multi) scans counted toward release
  kypd_state_e    state, state_nxt;
  logic [3:0]     cand, cand_nxt;
  logic [NW-1:0]  n, n_nxt;
  logic [3:0]     code_nxt;
  logic           valid_nxt, held_nxt;
  logic [5:0]     digit_nxt;
  logic           accept;
  logic [3:0]     acc_code;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= '0;
      n         <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      digit     <= '0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      n         <= n_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
      digit     <= digit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cand_nxt  = cand;
    n_nxt     = n;
    code_nxt  = key_code;
    valid_nxt = 1'b0;
    held_nxt  = key_held;
    digit_nxt = digit;
    accept    = 1'b0;
    acc_code  = cand;

    if (eos) begin
      case (state)
        IDLE: begin
          if (res == SINGLE) begin
            cand_nxt = hit_code;
            n_nxt    = NW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept   = 1'b1;
              acc_code = hit_code;
            end else begin
              state_nxt = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (res == SINGLE && hit_code == cand) begin
            if ((n + NW'(1)) == N_DONE) accept = 1'b1;
            else                        n_nxt  = n + NW'(1);
          end else begin
            state_nxt = IDLE;
            n_nxt     = '0;
          end
        end
        PRESSED: begin
          // Any lone key keeps the press alive; a new key needs a release first.
          if (res != SINGLE) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt = IDLE;
              held_nxt  = 1'b0;
              n_nxt     = '0;
            end else begin
              state_nxt = RELEASE;
              n_nxt     = NW'(1);
            end
          end
        end
        RELEASE: begin
          if (res != SINGLE) begin
            if ((n + NW'(1)) == N_DONE) begin
              state_nxt = IDLE;
              held_nxt  = 1'b0;
              n_nxt     = '0;
            end else begin
              n_nxt = n + NW'(1);
            end
          end else begin
            state_nxt = PRESSED;
            n_nxt     = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          n_nxt     = '0;
        end
      endcase
    end

    if (accept) begin
      state_nxt = PRESSED;
      n_nxt     = '0;
      code_nxt  = acc_code;
      valid_nxt = 1'b1;
      held_nxt  = 1'b1;
      digit_nxt = {1'b1, acc_code, 1'b0};
    end
  end

endmodule

// File: tb/tb_kypd_scan_rdr.sv
// tb_kypd_scan_rdr: drives a behavioural keypad (set of pressed keys held
// for whole scans) and compares the reader against a scan-level reference.
module tb_kypd_scan_rdr;

  localparam int ST       = 4;
  localparam int DB       = 3;
  localparam int SCAN_CYC = 4 * ST;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [5:0] digit;

  logic [15:0] keys = '0;   // bit {col,row} set = key pressed
  int checks = 0;
  int errors = 0;

  logic [3:0] key_map [16];

  // reference state
  logic       m_held;
  logic       m_enable;
  logic [3:0] m_code;
  logic [3:0] m_cand;
  int         m_run;
  int         m_rel;

  kypd_scan_rdr #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held),
    .digit     (digit)
  );

  always #5 clock = ~clock;

  // Passive matrix: a row reads low if a pressed key sits on a driven column.
  always_comb begin
    row = 4'b1111;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4 + r] && !col[c]) row[r] = 1'b0;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_held   = 1'b0;
    m_enable = 1'b0;
    m_code   = 4'h0;
    m_cand   = 4'h0;
    m_run    = 0;
    m_rel    = 0;
  endtask

  // One full scan of pressed set k: returns whether a press is accepted.
  task automatic model_scan(input logic [15:0] k, output logic acc);
    int cnt;
    int idx;
    logic [3:0] code;
    cnt = $countones(k);
    idx = 0;
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    code = key_map[idx];
    acc  = 1'b0;
    if (!m_held) begin
      if (cnt == 1 && (m_run == 0 || code == m_cand)) begin
        if (m_run == 0) m_cand = code;
        m_run++;
      end else begin
        m_run = 0;
      end
      if (m_run == DB) begin
        acc      = 1'b1;
        m_held   = 1'b1;
        m_enable = 1'b1;
        m_code   = m_cand;
        m_run    = 0;
        m_rel    = 0;
      end
    end else begin
      if (cnt == 1) m_rel = 0;
      else          m_rel++;
      if (m_rel == DB) begin
        m_held = 1'b0;
        m_rel  = 0;
      end
    end
  endtask

  task automatic check_outputs();
    logic [5:0] exp_digit;
    exp_digit = m_enable ? {1'b1, m_code, 1'b0} : 6'd0;
    check_val("key_held", key_held, m_held);
    check_val("key_code", key_code, m_code);
    check_val("digit", digit, exp_digit);
  endtask

  // Runs one scan starting on a tick-0 / column-0 cycle.
  task automatic do_scan(input logic [15:0] k);
    logic acc;
    logic [3:0] exp_col;
    keys = k;
    model_scan(k, acc);
    for (int i = 1; i <= SCAN_CYC; i++) begin
      @(posedge clock);
      #1;
      exp_col = ~(4'b0001 << ((i / ST) % 4));
      check_val("col", col, exp_col);
      check_val("key_valid", key_valid, (i == SCAN_CYC) ? acc : 1'b0);
    end
    check_outputs();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    check_val("rst_col", col, 4'b1110);
    check_val("rst_valid", key_valid, 1'b0);
    check_outputs();
    reset = 1'b0;
  endtask

  function automatic logic [15:0] kbit(input int idx);
    logic [15:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [15:0] cur;
    int a;
    int b;
    int sel;

    key_map[0]  = 4'h1; key_map[1]  = 4'h4; key_map[2]  = 4'h7; key_map[3]  = 4'h0;
    key_map[4]  = 4'h2; key_map[5]  = 4'h5; key_map[6]  = 4'h8; key_map[7]  = 4'hF;
    key_map[8]  = 4'h3; key_map[9]  = 4'h6; key_map[10] = 4'h9; key_map[11] = 4'hE;
    key_map[12] = 4'hA; key_map[13] = 4'hB; key_map[14] = 4'hC; key_map[15] = 4'hD;

    model_reset();
    apply_reset();

    // idle scanning, no keys
    repeat (3) do_scan('0);

    // key "5": col1 row1
    repeat (5) do_scan(kbit(5));
    check_val("code_5", key_code, 4'h5);
    check_val("digit_5", digit, 6'b1_0101_0);
    repeat (3) do_scan('0);

    // key "D" bouncing
    do_scan(kbit(15));
    do_scan('0);
    repeat (3) do_scan(kbit(15));
    check_val("code_D", key_code, 4'hD);
    repeat (3) do_scan('0);

    // "1" and "2" together, then "2" alone
    repeat (6) do_scan(kbit(0) | kbit(4));
    repeat (3) do_scan(kbit(4));
    check_val("code_2", key_code, 4'h2);
    repeat (3) do_scan('0);

    // "7" accepted, roll onto "8" without a release in between
    repeat (3) do_scan(kbit(2));
    repeat (2) do_scan(kbit(2) | kbit(6));
    repeat (2) do_scan(kbit(6));
    repeat (3) do_scan('0);
    check_val("code_7", key_code, 4'h7);
    check_val("held_7", key_held, 1'b0);

    // reset in the middle of qualifying "9"
    repeat (2) do_scan(kbit(10));
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      check_val("mid_valid", key_valid, 1'b0);
    end
    apply_reset();
    repeat (3) do_scan(kbit(10));
    check_val("code_9", key_code, 4'h9);
    repeat (3) do_scan('0);

    // randomized key activity
    cur = '0;
    for (int s = 0; s < 80; s++) begin
      if ($urandom_range(99, 0) >= 55) begin
        sel = $urandom_range(99, 0);
        a   = $urandom_range(15, 0);
        b   = (a + 1 + $urandom_range(14, 0)) % 16;
        if (sel < 35)      cur = '0;
        else if (sel < 80) cur = kbit(a);
        else               cur = kbit(a) | kbit(b);
      end
      do_scan(cur);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
